// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic voice bank: waveform select codes,
// envelope gain range and the mixer saturation helper.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW     = 2'b00,
    WAVE_SQUARE  = 2'b01,
    WAVE_TRI     = 2'b10,
    WAVE_PULSE25 = 2'b11
  } wave_sel_t;

  localparam int unsigned GAIN_W   = 9;
  localparam int unsigned GAIN_MAX = 256;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned      w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/synth_voice.sv
// One oscillator voice: detuned phase increment, phase accumulator,
// linear gate-driven envelope and waveform shaping into a registered output.
// Optional macro PHASE_RESET_ON_GATE_EN: restart phase on a gate rising edge.
module synth_voice
  import synth_pkg::*;
#(
  parameter bit          ODD          = 1'b0,
  parameter int unsigned FREQ_W       = 20,
  parameter int unsigned PHASE_W      = 24,
  parameter int unsigned WAVE_W       = 16,
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned RELEASE_STEP = 2,
  parameter int unsigned DETUNE_SHIFT = 10
) (
  input  logic              clock48kHz,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq,
  input  logic              gate,
  input  logic [1:0]        ctrl,
  input  logic [3:0]        detune,
  output logic [WAVE_W-1:0] wave
);

  localparam int unsigned PW = FREQ_W + 4;
  localparam int unsigned IW = (FREQ_W + 5 > PHASE_W + 1) ? FREQ_W + 5 : PHASE_W + 1;
  localparam logic signed [WAVE_W-1:0] POS_FS = signed'({1'b0, {(WAVE_W-1){1'b1}}});
  localparam logic signed [WAVE_W-1:0] NEG_FS = -POS_FS;

  logic [PHASE_W-1:0]             phase;
  logic [PHASE_W-1:0]             inc;
  logic [GAIN_W-1:0]              gain;
  logic [GAIN_W-1:0]              gain_nxt;
  logic signed [WAVE_W-1:0]       shp;
  logic signed [WAVE_W+GAIN_W:0]  scaled;

  // Detuned increment: even voices go sharp, odd voices flat, clamped to the accumulator range.
  always_comb begin
    logic [PW-1:0] prod;
    logic [PW-1:0] d;
    logic [IW-1:0] fw;
    logic [IW-1:0] dw;
    logic [IW-1:0] sum;
    prod = PW'(freq) * PW'(detune);
    d    = prod >> DETUNE_SHIFT;
    fw   = IW'(freq);
    dw   = IW'(d);
    if (ODD) sum = (dw > fw) ? '0 : fw - dw;
    else     sum = fw + dw;
    if (sum >= (IW'(1) << PHASE_W)) inc = '1;
    else                            inc = sum[PHASE_W-1:0];
  end

  // Linear attack towards full gain while gated, linear release towards zero otherwise.
  always_comb begin
    logic [GAIN_W:0] up;
    up       = {1'b0, gain} + (GAIN_W + 1)'(ATTACK_STEP);
    gain_nxt = gain;
    if (gate) begin
      gain_nxt = (up > (GAIN_W + 1)'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : up[GAIN_W-1:0];
    end else begin
      gain_nxt = (gain < GAIN_W'(RELEASE_STEP)) ? '0 : gain - GAIN_W'(RELEASE_STEP);
    end
  end

  // Waveform shaping on the top WAVE_W phase bits.
  always_comb begin
    logic [WAVE_W-1:0] p;
    logic [WAVE_W-1:0] tri_v;
    p     = phase[PHASE_W-1 -: WAVE_W];
    tri_v = {(p[WAVE_W-1] ? ~p[WAVE_W-2:0] : p[WAVE_W-2:0]), 1'b0};
    shp   = '0;
    case (wave_sel_t'(ctrl))
      WAVE_SAW:     shp = signed'({~p[WAVE_W-1], p[WAVE_W-2:0]});
      WAVE_SQUARE:  shp = p[WAVE_W-1] ? NEG_FS : POS_FS;
      WAVE_TRI:     shp = signed'({~tri_v[WAVE_W-1], tri_v[WAVE_W-2:0]});
      WAVE_PULSE25: shp = (p[WAVE_W-1:WAVE_W-2] == 2'b00) ? POS_FS : NEG_FS;
      default:      shp = '0;
    endcase
    scaled = shp * signed'({1'b0, gain});
  end

`ifdef PHASE_RESET_ON_GATE_EN
  logic gate_q;

  // Phase accumulator, restarted at zero on a gate rising edge.
  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) begin
      gate_q <= 1'b0;
      phase  <= '0;
    end else begin
      gate_q <= gate;
      phase  <= (gate && !gate_q) ? '0 : phase + inc;
    end
  end
`else
  // Free-running phase accumulator.
  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) phase <= '0;
    else       phase <= phase + inc;
  end
`endif

  // Envelope gain and enveloped output, both from pre-edge phase and gain.
  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) begin
      gain <= '0;
      wave <= '0;
    end else begin
      gain <= gain_nxt;
      wave <= WAVE_W'(scaled >>> 8);
    end
  end

endmodule

// File: rtl/poly_voice_bank.sv
// Polyphonic oscillator bank: NUM_VOICES synth_voice instances, a saturating
// mixer and a programmable tick divider.
// Optional macro PHASE_RESET_ON_GATE_EN (forwarded to synth_voice).
module poly_voice_bank
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 16,
  parameter int unsigned FREQ_W       = 20,
  parameter int unsigned PHASE_W      = 24,
  parameter int unsigned WAVE_W       = 16,
  parameter int unsigned MIX_W        = 20,
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned RELEASE_STEP = 2,
  parameter int unsigned DETUNE_SHIFT = 10,
  parameter int unsigned TICK_DIV     = 12000
) (
  input  logic                         clock48kHz,
  input  logic                         reset,
  input  logic [NUM_VOICES*FREQ_W-1:0] freq_flat,
  input  logic [NUM_VOICES-1:0]        gate,
  input  logic [1:0]                   ctrl,
  input  logic [3:0]                   detune,
  output logic [NUM_VOICES*WAVE_W-1:0] wave_flat,
  output logic [MIX_W-1:0]             mix_out,
  output logic                         mix_valid,
  output logic                         tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic signed [63:0] sum;
  logic [1:0]         fill;
  logic [CNT_W-1:0]   tick_cnt;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    synth_voice #(
      .ODD          (i % 2 == 1),
      .FREQ_W       (FREQ_W),
      .PHASE_W      (PHASE_W),
      .WAVE_W       (WAVE_W),
      .ATTACK_STEP  (ATTACK_STEP),
      .RELEASE_STEP (RELEASE_STEP),
      .DETUNE_SHIFT (DETUNE_SHIFT)
    ) u_voice (
      .clock48kHz (clock48kHz),
      .reset      (reset),
      .freq       (freq_flat[i*FREQ_W +: FREQ_W]),
      .gate       (gate[i]),
      .ctrl       (ctrl),
      .detune     (detune),
      .wave       (wave_flat[i*WAVE_W +: WAVE_W])
    );
  end

  // Sign-extended sum of all registered voice outputs.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      sum = sum + 64'(signed'(wave_flat[i*WAVE_W +: WAVE_W]));
    end
  end

  // Saturated mix register and pipeline-fill flag.
  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) begin
      mix_out <= '0;
      fill    <= '0;
    end else begin
      mix_out <= MIX_W'(sat_signed(sum, MIX_W));
      fill    <= {fill[0], 1'b1};
    end
  end

  assign mix_valid = fill[1];

  // Tick divider: pulse for the cycle following the terminal count.
  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (tick_cnt == CNT_W'(TICK_DIV - 1));
      tick_cnt <= (tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule
